// File: rtl/cacheline_burst_adaptor_pkg.sv
// Shared types and sizing for the cache-line to DRAM burst adaptor.
// Optional perf counters are enabled by defining ADAPTOR_PERF_CNT_EN.
package cacheline_adaptor_types;

    localparam int unsigned BEATS            = 4;
    localparam int unsigned BEAT_IDX_W       = 2;
    localparam int unsigned LINE_OFFSET_BITS = 5;

    typedef enum logic [1:0] {
        IDLE,
        RD_BURST,
        WR_BURST,
        DONE
    } adaptor_state_t;

endpackage

// File: rtl/cacheline_burst_adaptor_beat_buffer.sv
// Line-wide staging register: whole-line load from the cache, per-beat load from
// DRAM, and per-beat select toward DRAM. Part of cacheline_burst_adaptor.
module cacheline_beat_buffer
    import cacheline_adaptor_types::*;
#(
    parameter int unsigned LINE_WIDTH  = 256,
    parameter int unsigned BURST_WIDTH = 64
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   i_line_load,
    input  logic [LINE_WIDTH-1:0]  i_line,
    input  logic                   i_beat_load,
    input  logic [BEAT_IDX_W-1:0]  i_beat_idx,
    input  logic [BURST_WIDTH-1:0] i_beat_data,
    input  logic [BEAT_IDX_W-1:0]  i_sel_idx,
    output logic [BURST_WIDTH-1:0] o_sel_beat_c,
    output logic [LINE_WIDTH-1:0]  o_line_next_c
);

    logic [LINE_WIDTH-1:0] r_line;
    logic [LINE_WIDTH-1:0] w_line_next;

    // Next-line value is exported so the top can capture a completed read in the same edge.
    always_comb begin
        w_line_next = r_line;
        if (i_line_load) begin
            w_line_next = i_line;
        end else if (i_beat_load) begin
            for (int b = 0; b < BEATS; b++) begin
                if (i_beat_idx == BEAT_IDX_W'(b)) begin
                    w_line_next[b*BURST_WIDTH +: BURST_WIDTH] = i_beat_data;
                end
            end
        end
    end

    always_comb begin
        o_sel_beat_c = '0;
        for (int b = 0; b < BEATS; b++) begin
            if (i_sel_idx == BEAT_IDX_W'(b)) begin
                o_sel_beat_c = r_line[b*BURST_WIDTH +: BURST_WIDTH];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_line <= '0;
        end else begin
            r_line <= w_line_next;
        end
    end

    assign o_line_next_c = w_line_next;

endmodule

// File: rtl/cacheline_burst_adaptor.sv
// Converts one cache-line read/write into a four-beat DRAM burst.
// Define ADAPTOR_PERF_CNT_EN to add rd_count_o/wr_count_o completion counters.
module cacheline_burst_adaptor
    import cacheline_adaptor_types::*;
#(
    parameter int unsigned LINE_WIDTH  = 256,
    parameter int unsigned BURST_WIDTH = 64,
    parameter int unsigned ADDR_WIDTH  = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   read_i,
    input  logic                   write_i,
    input  logic [ADDR_WIDTH-1:0]  address_i,
    input  logic [LINE_WIDTH-1:0]  line_i,
    output logic [LINE_WIDTH-1:0]  line_o,
    output logic                   resp_o,
    output logic                   read_o,
    output logic                   write_o,
    output logic [ADDR_WIDTH-1:0]  address_o,
    output logic [BURST_WIDTH-1:0] burst_o,
    input  logic [BURST_WIDTH-1:0] burst_i,
    input  logic                   resp_i
`ifdef ADAPTOR_PERF_CNT_EN
    ,
    output logic [31:0]            rd_count_o,
    output logic [31:0]            wr_count_o
`endif
);

    adaptor_state_t         r_state;
    logic [BEAT_IDX_W-1:0]  r_beat;
    logic                   r_read_o;
    logic                   r_write_o;
    logic                   r_resp_o;
    logic [ADDR_WIDTH-1:0]  r_address_o;
    logic [BURST_WIDTH-1:0] r_burst_o;
    logic [LINE_WIDTH-1:0]  r_line_o;

    logic                   w_line_load;
    logic                   w_beat_load;
    logic [BEAT_IDX_W-1:0]  w_next_beat;
    logic [BURST_WIDTH-1:0] w_sel_beat;
    logic [LINE_WIDTH-1:0]  w_line_next;
    logic                   w_unused_addr;

    assign w_line_load   = (r_state == IDLE) && write_i;
    assign w_beat_load   = (r_state == RD_BURST) && resp_i;
    assign w_next_beat   = r_beat + 2'd1;
    assign w_unused_addr = ^address_i[LINE_OFFSET_BITS-1:0];

    cacheline_beat_buffer #(
        .LINE_WIDTH  (LINE_WIDTH),
        .BURST_WIDTH (BURST_WIDTH)
    ) u_buffer (
        .clk           (clk),
        .rst           (rst),
        .i_line_load   (w_line_load),
        .i_line        (line_i),
        .i_beat_load   (w_beat_load),
        .i_beat_idx    (r_beat),
        .i_beat_data   (burst_i),
        .i_sel_idx     (w_next_beat),
        .o_sel_beat_c  (w_sel_beat),
        .o_line_next_c (w_line_next)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= IDLE;
            r_beat      <= '0;
            r_read_o    <= 1'b0;
            r_write_o   <= 1'b0;
            r_resp_o    <= 1'b0;
            r_address_o <= '0;
            r_burst_o   <= '0;
            r_line_o    <= '0;
        end else begin
            r_resp_o <= 1'b0;
            case (r_state)
                IDLE: begin
                    r_beat <= '0;
                    if (write_i) begin
                        r_state     <= WR_BURST;
                        r_write_o   <= 1'b1;
                        r_address_o <= {address_i[ADDR_WIDTH-1:LINE_OFFSET_BITS], LINE_OFFSET_BITS'(0)};
                        r_burst_o   <= line_i[BURST_WIDTH-1:0];
                    end else if (read_i) begin
                        r_state     <= RD_BURST;
                        r_read_o    <= 1'b1;
                        r_address_o <= {address_i[ADDR_WIDTH-1:LINE_OFFSET_BITS], LINE_OFFSET_BITS'(0)};
                    end
                end
                RD_BURST: begin
                    if (resp_i) begin
                        r_beat <= w_next_beat;
                        if (r_beat == BEAT_IDX_W'(BEATS - 1)) begin
                            r_read_o <= 1'b0;
                            r_resp_o <= 1'b1;
                            r_line_o <= w_line_next;
                            r_state  <= DONE;
                        end
                    end
                end
                WR_BURST: begin
                    // burst_o is pre-loaded with the following beat so it is stable during gaps
                    if (resp_i) begin
                        r_beat <= w_next_beat;
                        if (r_beat == BEAT_IDX_W'(BEATS - 1)) begin
                            r_write_o <= 1'b0;
                            r_resp_o  <= 1'b1;
                            r_state   <= DONE;
                        end else begin
                            r_burst_o <= w_sel_beat;
                        end
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign line_o    = r_line_o;
    assign resp_o    = r_resp_o;
    assign read_o    = r_read_o;
    assign write_o   = r_write_o;
    assign address_o = r_address_o;
    assign burst_o   = r_burst_o;

`ifdef ADAPTOR_PERF_CNT_EN
    logic        r_op_wr;
    logic [31:0] r_rd_count;
    logic [31:0] r_wr_count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_op_wr    <= 1'b0;
            r_rd_count <= '0;
            r_wr_count <= '0;
        end else begin
            if (r_state == IDLE) begin
                if (write_i) begin
                    r_op_wr <= 1'b1;
                end else if (read_i) begin
                    r_op_wr <= 1'b0;
                end
            end
            if (r_state == DONE) begin
                if (r_op_wr) begin
                    r_wr_count <= r_wr_count + 32'd1;
                end else begin
                    r_rd_count <= r_rd_count + 32'd1;
                end
            end
        end
    end

    assign rd_count_o = r_rd_count;
    assign wr_count_o = r_wr_count;
`endif

endmodule
